// File: rtl/yoshi_health_ctrl_if.sv
// Bus between the ghost/start inputs and the health controller outputs.
// The master drives the hit flags and pulses; the slave (the controller)
// drives the life count, game state and renderer/ghost control outputs.
interface yoshi_health_ctrl_if;
    logic       frame_tick;
    logic       game_start;
    logic       got_hit1;
    logic       got_hit2;
    logic       got_hit3;
    logic       got_hit4;
    logic [2:0] lives;
    logic [1:0] state;
    logic       invincible;
    logic       sprite_visible;
    logic       hit_pulse;
    logic       ghosts_reset;
    logic       game_over;

    modport master (
        output frame_tick, game_start, got_hit1, got_hit2, got_hit3, got_hit4,
        input  lives, state, invincible, sprite_visible, hit_pulse, ghosts_reset, game_over
    );

    modport slave (
        input  frame_tick, game_start, got_hit1, got_hit2, got_hit3, got_hit4,
        output lives, state, invincible, sprite_visible, hit_pulse, ghosts_reset, game_over
    );
endinterface

// File: rtl/yoshi_health_ctrl.sv
// Yoshi health controller: life count, post-hit invincibility with sprite
// blink, and the idle/play/hurt/over game state. All outputs are registered.
module yoshi_health_ctrl #(
    parameter logic [2:0] MAX_LIVES     = 3'd3,   // 1..7
    parameter logic [7:0] INVINC_FRAMES = 8'd120, // >= 1
    parameter logic [3:0] BLINK_PERIOD  = 4'd8    // >= 1
) (
    input  logic                  clk,
    input  logic                  rst,
    yoshi_health_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StHurt = 2'd2,
        StOver = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [7:0] inv_cnt_q, inv_cnt_d;
    logic [3:0] blink_cnt_q, blink_cnt_d;
    logic       invincible_q, invincible_d;
    logic       sprite_visible_q, sprite_visible_d;
    logic       hit_pulse_q, hit_pulse_d;
    logic       ghosts_reset_q, ghosts_reset_d;
    logic       game_over_q, game_over_d;

    logic       any_hit;

    // Simultaneous overlaps collapse into a single hit.
    assign any_hit = bus.got_hit1 | bus.got_hit2 | bus.got_hit3 | bus.got_hit4;

    // Next-state logic for the game FSM, counters and registered outputs.
    always_comb begin
        state_d          = state_q;
        lives_d          = lives_q;
        inv_cnt_d        = inv_cnt_q;
        blink_cnt_d      = blink_cnt_q;
        sprite_visible_d = sprite_visible_q;
        hit_pulse_d      = 1'b0;
        ghosts_reset_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.game_start) begin
                    state_d          = StPlay;
                    lives_d          = MAX_LIVES;
                    sprite_visible_d = 1'b1;
                    ghosts_reset_d   = 1'b1;
                end
            end
            StPlay: begin
                // A frame_tick coinciding with the hit is deliberately dropped:
                // the invincibility window always starts from the full count.
                if (any_hit) begin
                    hit_pulse_d = 1'b1;
                    if (lives_q <= 3'd1) begin
                        lives_d          = 3'd0;
                        state_d          = StOver;
                        sprite_visible_d = 1'b1;
                    end else begin
                        lives_d          = lives_q - 3'd1;
                        state_d          = StHurt;
                        inv_cnt_d        = INVINC_FRAMES;
                        blink_cnt_d      = BLINK_PERIOD;
                        sprite_visible_d = 1'b0;
                    end
                end
            end
            StHurt: begin
                if (bus.frame_tick) begin
                    inv_cnt_d = inv_cnt_q - 8'd1;
                    if (blink_cnt_q == 4'd1) begin
                        blink_cnt_d      = BLINK_PERIOD;
                        sprite_visible_d = ~sprite_visible_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q - 4'd1;
                    end
                    // Leaving invincibility always shows the sprite, whatever the blink phase.
                    if (inv_cnt_q == 8'd1) begin
                        state_d          = StPlay;
                        sprite_visible_d = 1'b1;
                    end
                end
            end
            StOver: begin
                sprite_visible_d = 1'b1;
                lives_d          = 3'd0;
                if (bus.game_start) begin
                    state_d        = StPlay;
                    lives_d        = MAX_LIVES;
                    ghosts_reset_d = 1'b1;
                end
            end
        endcase

        invincible_d = (state_d == StHurt);
        game_over_d  = (state_d == StOver);
    end

    // State register; synchronous reset takes priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            lives_q          <= MAX_LIVES;
            inv_cnt_q        <= 8'd0;
            blink_cnt_q      <= 4'd0;
            invincible_q     <= 1'b0;
            sprite_visible_q <= 1'b1;
            hit_pulse_q      <= 1'b0;
            ghosts_reset_q   <= 1'b0;
            game_over_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            lives_q          <= lives_d;
            inv_cnt_q        <= inv_cnt_d;
            blink_cnt_q      <= blink_cnt_d;
            invincible_q     <= invincible_d;
            sprite_visible_q <= sprite_visible_d;
            hit_pulse_q      <= hit_pulse_d;
            ghosts_reset_q   <= ghosts_reset_d;
            game_over_q      <= game_over_d;
        end
    end

    assign bus.lives          = lives_q;
    assign bus.state          = state_q;
    assign bus.invincible     = invincible_q;
    assign bus.sprite_visible = sprite_visible_q;
    assign bus.hit_pulse      = hit_pulse_q;
    assign bus.ghosts_reset   = ghosts_reset_q;
    assign bus.game_over      = game_over_q;

endmodule

// File: tb/tb_yoshi_health_ctrl.sv
// Testbench for yoshi_health_ctrl: a short-window instance driven from a
// vector table, and a default-parameter instance for a long invincibility run.
module tb_yoshi_health_ctrl;

    logic clk = 1'b0;
    logic rst_a, rst_b;

    always #5 clk = ~clk;

    yoshi_health_ctrl_if if_a ();
    yoshi_health_ctrl_if if_b ();

    yoshi_health_ctrl #(
        .MAX_LIVES    (3'd3),
        .INVINC_FRAMES(8'd4),
        .BLINK_PERIOD (4'd2)
    ) dut_a (
        .clk(clk),
        .rst(rst_a),
        .bus(if_a.slave)
    );

    yoshi_health_ctrl dut_b (
        .clk(clk),
        .rst(rst_b),
        .bus(if_b.slave)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       ft;
        logic       gs;
        logic [3:0] hits;
        logic [2:0] lives;
        logic [1:0] st;
        logic       vis;
        logic       hp;
        logic       gr;
    } vec_t;

    vec_t       vecs[$];
    logic [9:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;

    wire [9:0] act_a = {if_a.lives, if_a.state, if_a.invincible, if_a.sprite_visible,
                        if_a.hit_pulse, if_a.ghosts_reset, if_a.game_over};
    wire [9:0] act_b = {if_b.lives, if_b.state, if_b.invincible, if_b.sprite_visible,
                        if_b.hit_pulse, if_b.ghosts_reset, if_b.game_over};

    // Expected output word; invincible and game_over follow the state encoding.
    function automatic logic [9:0] pk(input logic [2:0] lv, input logic [1:0] st,
                                      input logic vis, input logic hp, input logic gr);
        return {lv, st, (st == 2'd2), vis, hp, gr, (st == 2'd3)};
    endfunction

    function automatic void add(input string n, input logic r, input logic ft, input logic gs,
                                input logic [3:0] h, input logic [2:0] lv, input logic [1:0] st,
                                input logic vis, input logic hp, input logic gr);
        vec_t v;
        v.name = n; v.rst = r; v.ft = ft; v.gs = gs; v.hits = h;
        v.lives = lv; v.st = st; v.vis = vis; v.hp = hp; v.gr = gr;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input int which, input string n, input logic r, input logic ft,
                        input logic gs, input logic [3:0] h, input logic [9:0] e);
        logic [9:0] act, exp_v;
        string      nm;
        @(negedge clk);
        if (which == 0) begin
            rst_a = r; if_a.frame_tick = ft; if_a.game_start = gs;
            {if_a.got_hit4, if_a.got_hit3, if_a.got_hit2, if_a.got_hit1} = h;
        end else begin
            rst_b = r; if_b.frame_tick = ft; if_b.game_start = gs;
            {if_b.got_hit4, if_b.got_hit3, if_b.got_hit2, if_b.got_hit1} = h;
        end
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
        act   = (which == 0) ? act_a : act_b;
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got lives=%0d state=%0d inv=%b vis=%b hp=%b gr=%b go=%b, want lives=%0d state=%0d inv=%b vis=%b hp=%b gr=%b go=%b",
                     nm, act[9:7], act[6:5], act[4], act[3], act[2], act[1], act[0],
                     exp_v[9:7], exp_v[6:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        if_a.frame_tick = 1'b0; if_a.game_start = 1'b0;
        {if_a.got_hit4, if_a.got_hit3, if_a.got_hit2, if_a.got_hit1} = 4'b0;
        if_b.frame_tick = 1'b0; if_b.game_start = 1'b0;
        {if_b.got_hit4, if_b.got_hit3, if_b.got_hit2, if_b.got_hit1} = 4'b0;

        //    name             rst ft gs hits     lives st vis hp gr
        add("reset",           1, 0, 0, 4'b0000, 3, 0, 1, 0, 0);
        add("idle",            0, 0, 0, 4'b0000, 3, 0, 1, 0, 0);
        add("idle_hits_ign",   0, 1, 0, 4'b1111, 3, 0, 1, 0, 0);
        add("idle2",           0, 0, 0, 4'b0000, 3, 0, 1, 0, 0);
        add("idle3",           0, 0, 0, 4'b0000, 3, 0, 1, 0, 0);
        add("start",           0, 0, 1, 4'b0000, 3, 1, 1, 0, 1);
        add("start_pulse_end", 0, 0, 0, 4'b0000, 3, 1, 1, 0, 0);
        add("play_gs_ign",     0, 0, 1, 4'b0000, 3, 1, 1, 0, 0);
        add("dual_hit",        0, 0, 0, 4'b1010, 2, 2, 0, 1, 0);
        add("hurt_entry",      0, 0, 0, 4'b0000, 2, 2, 0, 0, 0);
        add("hurt_t1",         0, 1, 0, 4'b0001, 2, 2, 0, 0, 0);
        add("hurt_gs_ign",     0, 0, 1, 4'b0001, 2, 2, 0, 0, 0);
        add("hurt_t2_blink",   0, 1, 0, 4'b0001, 2, 2, 1, 0, 0);
        add("hurt_t3",         0, 1, 0, 4'b0001, 2, 2, 1, 0, 0);
        add("hurt_t4_exit",    0, 1, 0, 4'b0001, 2, 1, 1, 0, 0);
        add("held_hit_taken",  0, 0, 0, 4'b0001, 1, 2, 0, 1, 0);
        add("hurt2_entry",     0, 0, 0, 4'b0000, 1, 2, 0, 0, 0);
        add("hurt2_t1",        0, 1, 0, 4'b0000, 1, 2, 0, 0, 0);
        add("hurt2_t2",        0, 1, 0, 4'b0000, 1, 2, 1, 0, 0);
        add("hurt2_t3",        0, 1, 0, 4'b0000, 1, 2, 1, 0, 0);
        add("hurt2_exit",      0, 1, 0, 4'b0000, 1, 1, 1, 0, 0);
        add("last_life",       0, 1, 0, 4'b0100, 0, 3, 1, 1, 0);
        add("over_hits_ign",   0, 0, 0, 4'b1111, 0, 3, 1, 0, 0);
        add("over_tick",       0, 1, 0, 4'b0000, 0, 3, 1, 0, 0);
        add("restart",         0, 0, 1, 4'b0000, 3, 1, 1, 0, 1);
        add("restart_end",     0, 0, 0, 4'b0000, 3, 1, 1, 0, 0);
        add("hit_with_tick",   0, 1, 0, 4'b1000, 2, 2, 0, 1, 0);
        add("hwt_t1",          0, 1, 0, 4'b0000, 2, 2, 0, 0, 0);
        add("hwt_t2",          0, 1, 0, 4'b0000, 2, 2, 1, 0, 0);
        add("hwt_t3_stay",     0, 1, 0, 4'b0000, 2, 2, 1, 0, 0);
        add("hwt_t4_exit",     0, 1, 0, 4'b0000, 2, 1, 1, 0, 0);
        add("hit_again",       0, 0, 0, 4'b0010, 1, 2, 0, 1, 0);
        add("hurt3_t1",        0, 1, 0, 4'b0000, 1, 2, 0, 0, 0);
        add("rst_in_hurt",     1, 1, 1, 4'b1111, 3, 0, 1, 0, 0);
        add("rst_gs_ign",      1, 0, 1, 4'b0000, 3, 0, 1, 0, 0);
        add("post_rst_idle",   0, 0, 0, 4'b0000, 3, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            step(0, vecs[i].name, vecs[i].rst, vecs[i].ft, vecs[i].gs, vecs[i].hits,
                 pk(vecs[i].lives, vecs[i].st, vecs[i].vis, vecs[i].hp, vecs[i].gr));
        end

        // Default parameters: long invincibility window, reset at inv_cnt=50.
        step(1, "b_reset", 1, 0, 0, 4'b0000, pk(3, 0, 1, 0, 0));
        step(1, "b_start", 0, 0, 1, 4'b0000, pk(3, 1, 1, 0, 1));
        step(1, "b_hit",   0, 0, 0, 4'b0100, pk(2, 2, 0, 1, 0));
        for (int k = 1; k <= 70; k++) begin
            // Sprite toggles every 8 ticks starting hidden.
            step(1, $sformatf("b_hurt_tick%0d", k), 0, 1, 0, 4'b0001,
                 pk(2, 2, ((k / 8) % 2) == 1, 0, 0));
        end
        step(1, "b_rst_mid_hurt", 1, 0, 1, 4'b1111, pk(3, 0, 1, 0, 0));
        step(1, "b_rst_gs_ign",   1, 0, 1, 4'b0000, pk(3, 0, 1, 0, 0));
        step(1, "b_idle",         0, 0, 0, 4'b0000, pk(3, 0, 1, 0, 0));
        step(1, "b_restart",      0, 0, 1, 4'b0000, pk(3, 1, 1, 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
